// File: rtl/icache_arb_pkg.sv
// icache_arb_pkg: shared constants and state encoding for the icache request arbiter
package icache_arb_pkg;
    localparam int NUM_PORTS   = 16;
    localparam int SEL_W       = 4;
    localparam int ADDR_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
endpackage

// File: rtl/icache_req_arbiter_rr_pick16.sv
// rr_pick16: first set request bit at or above ptr, searching upward with wrap 15->0
module rr_pick16
    import icache_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic                 found,
    output logic [SEL_W-1:0]     idx
);
    logic [NUM_PORTS-1:0] rot;
    logic [SEL_W-1:0]     off;
    always_comb begin
        rot = NUM_PORTS'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (rot[i]) off = SEL_W'(i);
        found = |req;
        idx   = ptr + off;
    end
endmodule

// File: rtl/icache_req_arbiter.sv
// icache_req_arbiter: 16-port round-robin arbiter, one outstanding cache request; ICACHE_ARB_TIMEOUT_EN adds a response watchdog
module icache_req_arbiter
    import icache_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    output logic [NUM_PORTS-1:0]        grant,
    output logic [SEL_W-1:0]            sel,
    output logic                        cache_req_valid,
    output logic [ADDR_W-1:0]           cache_req_addr,
    input  logic                        cache_req_ready,
    input  logic                        cache_resp_valid,
    output logic                        timeout_err
);
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d, sel_q, sel_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 found, to_hit;
    logic [SEL_W-1:0]     idx;

`ifdef ICACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q;
`endif

    rr_pick16 u_pick (.req(req), .ptr(ptr_q), .found(found), .idx(idx));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        to_hit  = 1'b0;
`ifdef ICACHE_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (found) begin
                state_d = REQ;
                sel_d   = idx;
                grant_d = NUM_PORTS'(1) << idx;
                valid_d = 1'b1;
                addr_d  = req_addr[idx*ADDR_W +: ADDR_W];
            end
            REQ: if (cache_req_ready) begin
                state_d = WAIT;
                valid_d = 1'b0;
`ifdef ICACHE_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
`ifdef ICACHE_ARB_TIMEOUT_EN
                cnt_d  = cnt_q + 1'b1;
                // a response landing on the expiry cycle completes normally
                to_hit = !cache_resp_valid && (cnt_d == CNT_W'(TIMEOUT));
`endif
                if (cache_resp_valid || to_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

`ifdef ICACHE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= to_hit;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant           = grant_q;
    assign sel             = sel_q;
    assign cache_req_valid = valid_q;
    assign cache_req_addr  = addr_q;
endmodule

// File: tb/tb_icache_req_arbiter.sv
// tb_icache_req_arbiter: directed vector table, corner sequences and random traffic against a transaction-level model
module tb_icache_req_arbiter;
    import icache_arb_pkg::*;
`ifdef ICACHE_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     req = '0;
    logic [16*AW-1:0] req_addr = '0;
    logic [15:0]     grant;
    logic [3:0]      sel;
    logic            cache_req_valid;
    logic [AW-1:0]   cache_req_addr;
    logic            cache_req_ready = 1'b0;
    logic            cache_resp_valid = 1'b0;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    icache_req_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .grant(grant), .sel(sel), .cache_req_valid(cache_req_valid),
        .cache_req_addr(cache_req_addr), .cache_req_ready(cache_req_ready),
        .cache_resp_valid(cache_resp_valid), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // transaction-level reference: owner, whether the request was sent, fairness pointer
    typedef struct packed {
        logic        active;
        logic        sent;
        logic [3:0]  owner;
        logic [3:0]  ptr;
        logic [31:0] addr;
        logic        terr;
        logic [15:0] waited;
    } mdl_t;
    mdl_t m;

    function automatic mdl_t model_next(mdl_t c, logic [15:0] r, logic [16*AW-1:0] a, logic rdy, logic rsp);
        mdl_t n = c;
        int p;
        n.terr = 1'b0;
        if (!c.active) begin
            for (int k = 15; k >= 0; k--) begin
                p = (int'(c.ptr) + k) % 16;
                if (r[p]) begin
                    n.active = 1'b1;
                    n.sent = 1'b0;
                    n.owner = 4'(p);
                    n.addr = a[p*AW +: AW];
                end
            end
        end else if (!c.sent) begin
            if (rdy) begin
                n.sent = 1'b1;
                n.waited = '0;
            end
        end else if (rsp) begin
            n.active = 1'b0;
            n.ptr = 4'((int'(c.owner) + 1) % 16);
        end else begin
            n.waited = c.waited + 16'd1;
`ifdef ICACHE_ARB_TIMEOUT_EN
            if (int'(n.waited) == TO) begin
                n.terr = 1'b1;
                n.active = 1'b0;
                n.ptr = 4'((int'(c.owner) + 1) % 16);
            end
`endif
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '0;
        else m <= model_next(m, req, req_addr, cache_req_ready, cache_resp_valid);

    always @(posedge clk)
        if (rst_n && cache_req_valid && cache_req_ready) xfers <= xfers + 1;

    always @(negedge clk)
        if (chk_en && rst_n) begin
            check("model_grant", 64'(grant), m.active ? 64'(16'd1 << m.owner) : 64'd0);
            check("model_sel", 64'(sel), 64'(m.owner));
            check("model_valid", 64'(cache_req_valid), 64'(m.active && !m.sent));
            check("model_addr", 64'(cache_req_addr), 64'(m.addr));
            check("model_terr", 64'(timeout_err), 64'(m.terr));
        end

    task automatic set_addrs();
        for (int i = 0; i < 16; i++) req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
        req_addr[4*AW +: AW] = 32'h0000_1A40;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        cache_req_ready = 1'b0;
        cache_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] req;
        logic        rdy;
        logic        resp;
        logic [15:0] grant;
        logic [3:0]  sel;
        logic        valid;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl[18];

    initial begin
        tbl[0]  = '{16'h0010, 1'b1, 1'b0, 16'h0010, 4'd4,  1'b1, 32'h1A40};
        tbl[1]  = '{16'h0010, 1'b1, 1'b0, 16'h0010, 4'd4,  1'b0, 32'h1A40};
        tbl[2]  = '{16'h0000, 1'b1, 1'b0, 16'h0010, 4'd4,  1'b0, 32'h1A40};
        tbl[3]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 4'd4,  1'b0, 32'h1A40};
        tbl[4]  = '{16'h0000, 1'b1, 1'b1, 16'h0000, 4'd4,  1'b0, 32'h1A40};
        tbl[5]  = '{16'h1008, 1'b1, 1'b0, 16'h1000, 4'd12, 1'b1, 32'h10C0};
        tbl[6]  = '{16'h1008, 1'b1, 1'b0, 16'h1000, 4'd12, 1'b0, 32'h10C0};
        tbl[7]  = '{16'h1008, 1'b1, 1'b1, 16'h0000, 4'd12, 1'b0, 32'h10C0};
        tbl[8]  = '{16'h1008, 1'b1, 1'b0, 16'h0008, 4'd3,  1'b1, 32'h1030};
        tbl[9]  = '{16'h1008, 1'b1, 1'b0, 16'h0008, 4'd3,  1'b0, 32'h1030};
        tbl[10] = '{16'h1008, 1'b1, 1'b1, 16'h0000, 4'd3,  1'b0, 32'h1030};
        tbl[11] = '{16'h1008, 1'b1, 1'b0, 16'h1000, 4'd12, 1'b1, 32'h10C0};
        tbl[12] = '{16'h1008, 1'b1, 1'b0, 16'h1000, 4'd12, 1'b0, 32'h10C0};
        tbl[13] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 4'd12, 1'b0, 32'h10C0};
        tbl[14] = '{16'h0008, 1'b0, 1'b1, 16'h0008, 4'd3,  1'b1, 32'h1030};
        tbl[15] = '{16'h0000, 1'b0, 1'b1, 16'h0008, 4'd3,  1'b1, 32'h1030};
        tbl[16] = '{16'h0000, 1'b1, 1'b0, 16'h0008, 4'd3,  1'b0, 32'h1030};
        tbl[17] = '{16'h0000, 1'b1, 1'b1, 16'h0000, 4'd3,  1'b0, 32'h1030};

        set_addrs();
        do_reset();
        check("reset_grant", 64'(grant), 64'd0);
        check("reset_sel", 64'(sel), 64'd0);
        check("reset_valid", 64'(cache_req_valid), 64'd0);
        check("reset_addr", 64'(cache_req_addr), 64'd0);
        check("reset_terr", 64'(timeout_err), 64'd0);
        chk_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            req = tbl[i].req;
            cache_req_ready = tbl[i].rdy;
            cache_resp_valid = tbl[i].resp;
            @(negedge clk);
            check($sformatf("vec%0d_grant", i), 64'(grant), 64'(tbl[i].grant));
            check($sformatf("vec%0d_sel", i), 64'(sel), 64'(tbl[i].sel));
            check($sformatf("vec%0d_valid", i), 64'(cache_req_valid), 64'(tbl[i].valid));
            check($sformatf("vec%0d_addr", i), 64'(cache_req_addr), 64'(tbl[i].addr));
        end

        do_reset();
        req = 16'hFFFF;
        cache_req_ready = 1'b1;
        cache_resp_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check($sformatf("rot%0d_grant", k), 64'(grant), 64'(16'd1 << (k % 16)));
            check($sformatf("rot%0d_valid", k), 64'(cache_req_valid), 64'd1);
            @(negedge clk);
            check($sformatf("rot%0d_wait", k), 64'(grant), 64'(16'd1 << (k % 16)));
            @(negedge clk);
            check($sformatf("rot%0d_idle", k), 64'(grant), 64'd0);
        end

        do_reset();
        req = 16'h0200;
        @(negedge clk);
        xfers = 0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), 64'(cache_req_valid), 64'd1);
            check($sformatf("bp%0d_addr", i), 64'(cache_req_addr), 64'h1090);
            req = '0;
            req_addr[9*AW +: AW] = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        cache_req_ready = 1'b1;
        @(negedge clk);
        check("bp_wait_valid", 64'(cache_req_valid), 64'd0);
        check("bp_wait_grant", 64'(grant), 64'h0200);
        cache_req_ready = 1'b0;
        cache_resp_valid = 1'b1;
        @(negedge clk);
        cache_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_xfers", 64'(xfers), 64'd1);
        set_addrs();

        do_reset();
        req = 16'h0080;
        cache_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pre_sel", 64'(sel), 64'd7);
        check("rst_pre_grant", 64'(grant), 64'h0080);
        cache_resp_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_grant", 64'(grant), 64'd0);
        check("rst_mid_sel", 64'(sel), 64'd0);
        check("rst_mid_valid", 64'(cache_req_valid), 64'd0);
        check("rst_mid_addr", 64'(cache_req_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_post_grant", 64'(grant), 64'h0080);
        check("rst_post_sel", 64'(sel), 64'd7);
        cache_resp_valid = 1'b0;
        @(negedge clk);
        cache_resp_valid = 1'b1;
        @(negedge clk);
        cache_resp_valid = 1'b0;

`ifdef ICACHE_ARB_TIMEOUT_EN
        do_reset();
        req = 16'h0022;
        cache_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("to_owner", 64'(grant), 64'h0002);
        for (int c = 3; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("to_quiet%0d", c), 64'(timeout_err), 64'd0);
        end
        @(negedge clk);
        check("to_pulse", 64'(timeout_err), 64'd1);
        check("to_idle_grant", 64'(grant), 64'd0);
        @(negedge clk);
        check("to_pulse_end", 64'(timeout_err), 64'd0);
        check("to_next_grant", 64'(grant), 64'h0020);
        check("to_next_sel", 64'(sel), 64'd5);
        @(negedge clk);
        cache_resp_valid = 1'b1;
        @(negedge clk);
        cache_resp_valid = 1'b0;
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) & 16'($urandom));
            cache_req_ready = ($urandom_range(0, 9) < 7);
            cache_resp_valid = ($urandom_range(0, 19) < 3);
            if ($urandom_range(0, 7) == 0) req_addr[$urandom_range(0, 15)*AW +: AW] = $urandom;
            @(negedge clk);
        end
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
